ir_queue: RTL and testbench
===========================

IR_QUEUE -- requirements
Module: ir_queue

Interface
REQ-001 Parameter IR_width, default 12, SHALL set the instruction word width in bits (legal: >= 4).
REQ-002 Parameter DEPTH, default 4, SHALL set the number of instruction entries (legal: power of 2, >= 2).
REQ-003 Parameter OP_width, default 4, SHALL set the opcode field width, taken from the MSBs of the word (legal: 1 .. IR_width-1).
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: reset  input  1  reset; one clock, synchronous, active-high.
REQ-006 Port: write_en  input  1  load bus_data into tail this cycle.
REQ-007 Port: bus_data  input  IR_width  instruction word from bus.
REQ-008 Port: take  input  1  CU consumes head entry this cycle.
REQ-009 Port: flush  input  1  discard all entries (branch/redirect).
REQ-010 Port: dataout  output  IR_width  head instruction word.
REQ-011 Port: opcode  output  OP_width  dataout[IR_width-1 : IR_width-OP_width].
REQ-012 Port: operand  output  IR_width-OP_width  dataout[IR_width-OP_width-1 : 0].
REQ-013 Port: valid  output  1  queue holds >= 1 entry.
REQ-014 Port: full  output  1  queue holds DEPTH entries.
REQ-015 Port: count  output  clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-016 Port: overflow  output  1  sticky flag: a write was dropped.

Function
REQ-017 All state SHALL update only on rising clk; dataout/opcode/operand/valid/full SHALL be decoded from registered state only, never from same-cycle inputs.
REQ-018 Storage SHALL be a circular buffer: write pointer, read pointer, and count, with pointers wrapping DEPTH-1 -> 0.
REQ-019 Write accepted when write_en=1 and (full=0 or take=1); bus_data stored at tail, write pointer advances.
REQ-020 Take accepted when take=1 and valid=1; read pointer advances; take while valid=0 SHALL be ignored with no state change.
REQ-021 Accepted write and accepted take in the same cycle SHALL leave count unchanged; when full, this SHALL replace the head with no data loss.
REQ-022 Write while full without take SHALL be dropped, storage unchanged, and overflow SHALL set to 1.
REQ-023 overflow SHALL stay 1 until reset or flush.
REQ-024 flush=1 SHALL take priority over write_en and take: next cycle count=0, pointers=0, overflow=0, and same-cycle write_en is discarded.
REQ-025 dataout SHALL equal the head entry when valid=1 and all-zeros when valid=0.
REQ-026 Latency: a word written into an empty queue at edge N SHALL appear on dataout with valid=1 after edge N (one cycle).
REQ-027 valid = (count != 0); full = (count == DEPTH).
REQ-028 With no write_en, take, or flush, all outputs SHALL hold their values indefinitely.

Reset
REQ-029 reset=1 at a rising edge SHALL force count=0, both pointers=0, overflow=0, dataout=0, valid=0, full=0; storage contents need not be cleared.
REQ-030 reset SHALL take priority over flush, write_en and take, including mid-operation with a full queue.
REQ-031 Outputs are undefined before the first reset edge; the bench SHALL apply reset for >= 1 cycle first.

Verification
REQ-032 Reset, then write 12'hA51 once -> next cycle dataout=12'hA51, opcode=4'hA, operand=8'h51, valid=1, count=1.
REQ-033 Write 12'h001,002,003,004 on consecutive cycles (DEPTH=4) -> full=1, count=4; four takes return 001..004 in order, then valid=0, dataout=0.
REQ-034 Full queue, write 12'h0FF without take -> overflow=1, count=4, head still 12'h001; same with take=1 -> overflow stays 0, head becomes 12'h002, count=4, 12'h0FF later emerges fifth.
REQ-035 Three entries, assert flush with write_en=1 and bus_data=12'h777 -> next cycle count=0, valid=0, overflow=0, 12'h777 never appears.
REQ-036 Push/pop 10 words across pointer wrap (write and take each cycle after first write) -> output order matches input order, count stays 1.
REQ-037 Full queue with overflow=1, assert reset together with write_en and take -> next cycle all outputs zero, count=0.

Source files
------------

// File: rtl/ir_queue.sv
// Instruction prefetch queue: circular buffer between the fetch bus and the control unit.
// The head word is presented combinationally from registered state and split into opcode/operand.
module ir_queue #(
  parameter int IR_width = 12,
  parameter int DEPTH    = 4,
  parameter int OP_width = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write_en,
  input  logic [IR_width-1:0]        bus_data,
  input  logic                       take,
  input  logic                       flush,
  output logic [IR_width-1:0]        dataout,
  output logic [OP_width-1:0]        opcode,
  output logic [IR_width-OP_width-1:0] operand,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [IR_width-1:0] mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [PW:0]         cnt;
  logic                ovf;

  logic take_ok;
  logic write_ok;
  logic write_drop;

  assign valid = (cnt != '0);
  assign full  = (cnt == CNT_FULL);

  // A take frees the head slot in the same edge, so a full queue can still accept a write.
  assign take_ok    = take && valid;
  assign write_ok   = write_en && (!full || take_ok);
  assign write_drop = write_en && full && !take_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (write_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (take_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({write_ok, take_ok})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
      if (write_drop) begin
        ovf <= 1'b1;
      end
    end
  end

  // Storage is not cleared on reset; valid gates the head word instead.
  always_ff @(posedge clk) begin
    if (!reset && !flush && write_ok) begin
      mem[wr_ptr] <= bus_data;
    end
  end

  assign dataout  = valid ? mem[rd_ptr] : '0;
  assign opcode   = dataout[IR_width-1 -: OP_width];
  assign operand  = dataout[IR_width-OP_width-1:0];
  assign count    = cnt;
  assign overflow = ovf;

endmodule

// File: tb/tb_ir_queue.sv
// Directed bench for ir_queue: stimulus pushes expected head words into a scoreboard,
// a negedge monitor pops and compares them whenever the CU takes a valid entry.
module tb_ir_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        write_en = 1'b0;
  logic [11:0] bus_data = '0;
  logic        take = 1'b0;
  logic        flush = 1'b0;
  logic [11:0] dataout;
  logic [3:0]  opcode;
  logic [7:0]  operand;
  logic        valid;
  logic        full;
  logic [2:0]  count;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  ir_queue #(.IR_width(12), .DEPTH(4), .OP_width(4)) dut (
    .clk(clk), .reset(reset), .write_en(write_en), .bus_data(bus_data),
    .take(take), .flush(flush), .dataout(dataout), .opcode(opcode),
    .operand(operand), .valid(valid), .full(full), .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Inputs held across exactly one rising edge; returns 1 time unit after it.
  task automatic drive(input logic we, input logic [11:0] d, input logic tk,
                       input logic fl, input logic rs);
    write_en = we; bus_data = d; take = tk; flush = fl; reset = rs;
    @(posedge clk);
    #1;
    write_en = 1'b0; bus_data = '0; take = 1'b0; flush = 1'b0; reset = 1'b0;
  endtask

  task automatic wr(input logic [11:0] d);
    drive(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tk(input logic [11:0] e);
    exp_q.push_back(e);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic fill4();
    wr(12'h001); wr(12'h002); wr(12'h003); wr(12'h004);
  endtask

  // Monitor: an accepted take exposes the head word just before the edge.
  always @(negedge clk) begin
    if (!reset && !flush && take && valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL take_unexpected: got %0h, expected no take", dataout);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if (dataout !== e) begin
          errors++;
          $display("FAIL take_order: got %0h, expected %0h", dataout, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_data", 32'(dataout), 0);

    // Single word, one-cycle latency and field split
    wr(12'hA51);
    chk("a51_data", 32'(dataout), 32'h A51);
    chk("a51_opcode", 32'(opcode), 32'h A);
    chk("a51_operand", 32'(operand), 32'h 51);
    chk("a51_valid", 32'(valid), 1);
    chk("a51_count", 32'(count), 1);
    tk(12'hA51);
    chk("a51_empty_valid", 32'(valid), 0);
    chk("a51_empty_data", 32'(dataout), 0);

    // Fill, then drop a write while full
    fill4();
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 4);
    wr(12'h0FF);
    chk("drop_ovf", 32'(overflow), 1);
    chk("drop_count", 32'(count), 4);
    chk("drop_head", 32'(dataout), 32'h001);
    tk(12'h001); tk(12'h002); tk(12'h003); tk(12'h004);
    chk("drain_valid", 32'(valid), 0);
    chk("drain_data", 32'(dataout), 0);
    chk("drain_ovf_sticky", 32'(overflow), 1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("flush_clr_ovf", 32'(overflow), 0);

    // Full queue, write with take replaces the head
    fill4();
    exp_q.push_back(12'h001);
    drive(1'b1, 12'h0FF, 1'b1, 1'b0, 1'b0);
    chk("repl_ovf", 32'(overflow), 0);
    chk("repl_head", 32'(dataout), 32'h002);
    chk("repl_count", 32'(count), 4);
    tk(12'h002); tk(12'h003); tk(12'h004); tk(12'h0FF);
    chk("repl_empty", 32'(valid), 0);

    // Flush beats a same-cycle write
    wr(12'h111); wr(12'h222); wr(12'h333);
    drive(1'b1, 12'h777, 1'b0, 1'b1, 1'b0);
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(valid), 0);
    chk("flush_ovf", 32'(overflow), 0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("take_empty_count", 32'(count), 0);
    wr(12'h888);
    tk(12'h888);

    // Streaming across pointer wrap
    wr(12'h100);
    for (int i = 1; i < 10; i++) begin
      exp_q.push_back(12'h100 + 12'(i - 1));
      drive(1'b1, 12'h100 + 12'(i), 1'b1, 1'b0, 1'b0);
      chk($sformatf("stream_count_%0d", i), 32'(count), 1);
    end
    tk(12'h109);
    chk("stream_empty", 32'(valid), 0);

    // Reset dominates everything on a full, overflowed queue
    fill4();
    wr(12'h0AA);
    chk("pre_rst_ovf", 32'(overflow), 1);
    drive(1'b1, 12'h555, 1'b1, 1'b0, 1'b1);
    chk("rst2_count", 32'(count), 0);
    chk("rst2_valid", 32'(valid), 0);
    chk("rst2_full", 32'(full), 0);
    chk("rst2_ovf", 32'(overflow), 0);
    chk("rst2_data", 32'(dataout), 0);
    chk("rst2_opcode", 32'(opcode), 0);
    chk("rst2_operand", 32'(operand), 0);

    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("idle_hold_count", 32'(count), 0);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
